// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial line, rate select and received-byte outputs
// of the UART receiver.
//   baud_rate   - rate select (00=2400, 01=4800, 10=9600, 11=19200)
//   data_rx     - asynchronous serial line, idle high
//   data_out    - last correctly framed byte
//   done_flag   - one-cycle strobe per good frame
//   active_flag - frame in progress
//   error_flag  - framing error level (stop bit read as 0)
// Modports: master drives line/rate and observes results; slave is the receiver.
interface uart_rx_if;
  logic [1:0] baud_rate;
  logic       data_rx;
  logic [7:0] data_out;
  logic       done_flag;
  logic       active_flag;
  logic       error_flag;

  modport master (
    output baud_rate,
    output data_rx,
    input  data_out,
    input  done_flag,
    input  active_flag,
    input  error_flag
  );

  modport slave (
    input  baud_rate,
    input  data_rx,
    output data_out,
    output done_flag,
    output active_flag,
    output error_flag
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a 16x oversampling tick generator,
// 2-FF input synchroniser, start-bit validation and mid-bit sampling.
// Ports:
//   clk   - system clock (50 MHz nominal)
//   rst_n - asynchronous active-low reset
//   bus   - uart_rx_if.slave: baud_rate/data_rx in, data_out/done_flag/
//           active_flag/error_flag out (all outputs registered)
module uart_rx_core #(
  parameter int unsigned DIV_2400  = 1302,
  parameter int unsigned DIV_4800  = 651,
  parameter int unsigned DIV_9600  = 326,
  parameter int unsigned DIV_19200 = 163,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_r;
  logic                 sync1_r;
  logic                 rx_s_r;
  logic                 rx_s_d_r;
  logic [1:0]           div_sel_r;
  logic [10:0]          tick_cnt_r;
  logic [3:0]           bit_tick_r;
  logic [IDX_W-1:0]     bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [7:0]           data_out_r;
  logic                 done_r;
  logic                 active_r;
  logic                 error_r;

  logic [10:0]          div_s;
  logic                 tick_s;
  logic                 fall_s;

  // Divider for the rate latched at frame start, so mid-frame changes are ignored.
  always_comb begin
    div_s = 11'(DIV_9600);
    case (div_sel_r)
      2'b00:   div_s = 11'(DIV_2400);
      2'b01:   div_s = 11'(DIV_4800);
      2'b10:   div_s = 11'(DIV_9600);
      2'b11:   div_s = 11'(DIV_19200);
      default: div_s = 11'(DIV_9600);
    endcase
  end

  assign tick_s = (state_r != IDLE) && (tick_cnt_r == (div_s - 11'd1));
  // Edge detector runs in every state so an edge on the first IDLE cycle is seen.
  assign fall_s = rx_s_d_r & ~rx_s_r;

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= 1'b1;
      rx_s_r   <= 1'b1;
      rx_s_d_r <= 1'b1;
    end else begin
      sync1_r  <= bus.data_rx;
      rx_s_r   <= sync1_r;
      rx_s_d_r <= rx_s_r;
    end
  end

  // Receive FSM with tick counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      div_sel_r  <= 2'b00;
      tick_cnt_r <= 11'd0;
      bit_tick_r <= 4'd0;
      bit_idx_r  <= '0;
      shift_r    <= '0;
      data_out_r <= 8'h00;
      done_r     <= 1'b0;
      active_r   <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      // Held at zero while idle so tick phase is anchored to the start edge.
      if ((state_r == IDLE) || tick_s) begin
        tick_cnt_r <= 11'd0;
      end else begin
        tick_cnt_r <= tick_cnt_r + 11'd1;
      end

      case (state_r)
        IDLE: begin
          if (fall_s) begin
            state_r    <= START;
            div_sel_r  <= bus.baud_rate;
            tick_cnt_r <= 11'd0;
            bit_tick_r <= 4'd0;
            bit_idx_r  <= '0;
            active_r   <= 1'b1;
            error_r    <= 1'b0;
          end
        end
        START: begin
          if (tick_s) begin
            if (bit_tick_r == 4'd7) begin
              if (rx_s_r) begin
                // Line back high mid start bit: a glitch, not a frame.
                state_r  <= IDLE;
                active_r <= 1'b0;
              end else begin
                state_r    <= DATA;
                bit_tick_r <= 4'd0;
              end
            end else begin
              bit_tick_r <= bit_tick_r + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            if (bit_tick_r == 4'd15) begin
              bit_tick_r         <= 4'd0;
              shift_r[bit_idx_r] <= rx_s_r;
              if (bit_idx_r == IDX_W'(DATA_BITS - 1)) begin
                state_r <= STOP;
              end else begin
                bit_idx_r <= bit_idx_r + IDX_W'(1);
              end
            end else begin
              bit_tick_r <= bit_tick_r + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            if (bit_tick_r == 4'd15) begin
              state_r  <= IDLE;
              active_r <= 1'b0;
              if (rx_s_r) begin
                data_out_r <= shift_r[7:0];
                done_r     <= 1'b1;
                error_r    <= 1'b0;
              end else begin
                error_r <= 1'b1;
              end
            end else begin
              bit_tick_r <= bit_tick_r + 4'd1;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.done_flag   = done_r;
  assign bus.active_flag = active_r;
  assign bus.error_flag  = error_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core. Small
// dividers keep frames short; every bit is driven for 16*DIV clocks.
module tb_uart_rx_core;

  localparam int D0 = 40;
  localparam int D1 = 20;
  localparam int D2 = 10;
  localparam int D3 = 5;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   cyc;
  int   done_cnt;
  int   done_cyc;
  int   act_cnt;
  int   divs [4];

  uart_rx_if bus ();

  uart_rx_core #(
    .DIV_2400 (D0),
    .DIV_4800 (D1),
    .DIV_9600 (D2),
    .DIV_19200(D3),
    .DATA_BITS(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and width monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.done_flag === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.active_flag === 1'b1) act_cnt <= act_cnt + 1;
  end

  task automatic drive_bit(input logic b, input int div);
    bus.data_rx = b;
    repeat (16 * div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int div);
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++) drive_bit(d[i], div);
    drive_bit(stop, div);
    bus.data_rx = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.data_rx = 1'b1;
    bus.baud_rate = 2'b10;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data_out: got %h expected 00", bus.data_out); end
    tests_run++; if (bus.done_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.done_flag); end
    tests_run++; if (bus.active_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_active: got %b expected 0", bus.active_flag); end
    tests_run++; if (bus.error_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b expected 0", bus.error_flag); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++; if (bus.active_flag !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset: active got %b expected 0", bus.active_flag); end
  endtask

  task automatic test_basic_9600;
    int d0, a0, c0, lat;
    bus.baud_rate = 2'b10;
    d0 = done_cnt; a0 = act_cnt; c0 = cyc;
    send_frame(8'h55, 1'b1, D2);
    repeat (16 * D2) @(negedge clk);
    lat = done_cyc - c0;
    tests_run++; if (bus.data_out !== 8'h55) begin tests_failed++; $display("FAIL basic_data: got %h expected 55", bus.data_out); end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
    tests_run++; if (lat < 152 * D2 + 2 || lat > 152 * D2 + 4) begin tests_failed++; $display("FAIL basic_latency: got %0d expected %0d..%0d", lat, 152 * D2 + 2, 152 * D2 + 4); end
    tests_run++; if (bus.error_flag !== 1'b0) begin tests_failed++; $display("FAIL basic_error: got %b expected 0", bus.error_flag); end
    tests_run++; if (act_cnt - a0 < 152 * D2 - 1 || act_cnt - a0 > 152 * D2 + 1) begin tests_failed++; $display("FAIL basic_active_width: got %0d expected %0d", act_cnt - a0, 152 * D2); end
  endtask

  task automatic test_all_rates;
    int d0, a0;
    for (int r = 0; r < 4; r++) begin
      bus.baud_rate = 2'(r);
      d0 = done_cnt; a0 = act_cnt;
      send_frame(8'hA3, 1'b1, divs[r]);
      repeat (16 * divs[r]) @(negedge clk);
      tests_run++; if (bus.data_out !== 8'hA3) begin tests_failed++; $display("FAIL rate%0d_data: got %h expected a3", r, bus.data_out); end
      tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL rate%0d_done_count: got %0d expected 1", r, done_cnt - d0); end
      tests_run++; if (act_cnt - a0 < 152 * divs[r] - 1 || act_cnt - a0 > 152 * divs[r] + 1) begin tests_failed++; $display("FAIL rate%0d_active_width: got %0d expected %0d", r, act_cnt - a0, 152 * divs[r]); end
    end
  endtask

  task automatic test_glitch;
    int d0, a0;
    bus.baud_rate = 2'b10;
    d0 = done_cnt; a0 = act_cnt;
    bus.data_rx = 1'b0;
    repeat (3 * D2) @(negedge clk);
    bus.data_rx = 1'b1;
    repeat (32 * D2) @(negedge clk);
    tests_run++; if (done_cnt - d0 != 0) begin tests_failed++; $display("FAIL glitch_done: got %0d expected 0", done_cnt - d0); end
    tests_run++; if (bus.error_flag !== 1'b0) begin tests_failed++; $display("FAIL glitch_error: got %b expected 0", bus.error_flag); end
    tests_run++; if (bus.data_out !== 8'hA3) begin tests_failed++; $display("FAIL glitch_data: got %h expected a3", bus.data_out); end
    tests_run++; if (act_cnt - a0 < 8 * D2 - 1 || act_cnt - a0 > 8 * D2 + 1) begin tests_failed++; $display("FAIL glitch_active_width: got %0d expected %0d", act_cnt - a0, 8 * D2); end
  endtask

  task automatic test_framing;
    int d0;
    logic [7:0] nxt;
    bus.baud_rate = 2'b10;
    d0 = done_cnt;
    send_frame(8'h3C, 1'b0, D2);
    repeat (32 * D2) @(negedge clk);
    tests_run++; if (bus.error_flag !== 1'b1) begin tests_failed++; $display("FAIL framing_error: got %b expected 1", bus.error_flag); end
    tests_run++; if (done_cnt - d0 != 0) begin tests_failed++; $display("FAIL framing_done: got %0d expected 0", done_cnt - d0); end
    tests_run++; if (bus.data_out !== 8'hA3) begin tests_failed++; $display("FAIL framing_data_kept: got %h expected a3", bus.data_out); end
    d0 = done_cnt;
    nxt = 8'h81;
    bus.data_rx = 1'b0;
    repeat (8 * D2) @(negedge clk);
    tests_run++; if (bus.error_flag !== 1'b0) begin tests_failed++; $display("FAIL error_clear_on_start: got %b expected 0", bus.error_flag); end
    repeat (8 * D2) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(nxt[i], D2);
    drive_bit(1'b1, D2);
    repeat (16 * D2) @(negedge clk);
    tests_run++; if (bus.data_out !== 8'h81) begin tests_failed++; $display("FAIL recover_data: got %h expected 81", bus.data_out); end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL recover_done: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    int d0;
    bus.baud_rate = 2'b10;
    drive_bit(1'b0, D2);
    for (int i = 0; i < 5; i++) drive_bit(1'b1, D2);
    tests_run++; if (bus.active_flag !== 1'b1) begin tests_failed++; $display("FAIL midframe_active: got %b expected 1", bus.active_flag); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.data_out !== 8'h00) begin tests_failed++; $display("FAIL midreset_data: got %h expected 00", bus.data_out); end
    tests_run++; if (bus.active_flag !== 1'b0) begin tests_failed++; $display("FAIL midreset_active: got %b expected 0", bus.active_flag); end
    tests_run++; if (bus.done_flag !== 1'b0 || bus.error_flag !== 1'b0) begin tests_failed++; $display("FAIL midreset_flags: got done=%b err=%b expected 0 0", bus.done_flag, bus.error_flag); end
    bus.data_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (32 * D2) @(negedge clk);
    d0 = done_cnt;
    send_frame(8'h12, 1'b1, D2);
    repeat (16 * D2) @(negedge clk);
    tests_run++; if (bus.data_out !== 8'h12) begin tests_failed++; $display("FAIL post_reset_data: got %h expected 12", bus.data_out); end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL post_reset_done: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    int d0;
    bus.baud_rate = 2'b11;
    d0 = done_cnt;
    fork
      begin
        send_frame(8'h01, 1'b1, D3);
        send_frame(8'hFE, 1'b1, D3);
      end
      begin
        repeat (300) @(negedge clk); bus.baud_rate = 2'b00;
        repeat (400) @(negedge clk); bus.baud_rate = 2'b11;
        repeat (300) @(negedge clk); bus.baud_rate = 2'b01;
        repeat (400) @(negedge clk); bus.baud_rate = 2'b11;
      end
      begin
        repeat (790) @(negedge clk);
        tests_run++; if (bus.data_out !== 8'h01) begin tests_failed++; $display("FAIL b2b_first_data: got %h expected 01", bus.data_out); end
      end
    join
    repeat (16 * D3) @(negedge clk);
    tests_run++; if (bus.data_out !== 8'hFE) begin tests_failed++; $display("FAIL b2b_second_data: got %h expected fe", bus.data_out); end
    tests_run++; if (done_cnt - d0 != 2) begin tests_failed++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
    tests_run++; if (bus.error_flag !== 1'b0) begin tests_failed++; $display("FAIL b2b_error: got %b expected 0", bus.error_flag); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    done_cnt = 0;
    done_cyc = 0;
    act_cnt = 0;
    divs = '{D0, D1, D2, D3};
    test_reset();
    test_basic_9600();
    test_all_rates();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver paired with the existing BaudGenTx/transmitter path; same 50 MHz system clock and 2-bit baud select.
- Internal 16x oversampling baud generator, 2-FF input synchroniser, start-bit validation, mid-bit sampling, 8N1 deserialisation.
- Delivers a received byte with a one-cycle done strobe; flags framing errors.

Parameters:
- DIV_2400, 1302, clocks per 16x tick at baud_rate=2'b00 (2400 baud @ 50 MHz)
- DIV_4800, 651, clocks per tick at baud_rate=2'b01
- DIV_9600, 326, clocks per tick at baud_rate=2'b10
- DIV_19200, 163, clocks per tick at baud_rate=2'b11
- DATA_BITS, 8, data bits per frame, LSB first

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- baud_rate  input  2  rate select: 00=2400, 01=4800, 10=9600, 11=19200
- data_rx  input  1  serial line, idle high, asynchronous to clk
- data_out  output  8  last received byte
- done_flag  output  1  one-cycle pulse: frame received with valid stop bit
- active_flag  output  1  high while a frame is in progress (START..STOP)
- error_flag  output  1  framing error (stop bit sampled 0)

Behaviour:
- One clock; reset asynchronous, active-low. Reset values: data_out=8'h00, done_flag=0, active_flag=0, error_flag=0, state=IDLE, synchroniser flops=1, all counters 0.
- Synchroniser: data_rx -> 2 flops -> rx_s. A third flop holds rx_s_d for edge detection. All decisions use rx_s only.
- Baud select is latched into div_sel on the IDLE->START transition. Changing baud_rate mid-frame has no effect until the next frame.
- Tick generator: tick_cnt counts 0..DIV-1 and pulses tick for one clk at DIV-1.
  - tick_cnt is held at 0 in IDLE and cleared on entry to START, so the tick phase aligns to the start edge.
- bit_tick counts ticks 0..15 within a bit. bit_idx counts data bits 0..DATA_BITS-1.
- States:
  - IDLE: active_flag=0. A falling edge (rx_s_d=1, rx_s=0) moves to START and clears the counters.
  - START: on the 8th tick (mid start bit), sample rx_s.
    - rx_s=1: false start; return to IDLE with no flags asserted.
    - rx_s=0: go to DATA and clear bit_tick.
  - DATA: every 16th tick, sample rx_s into shift register bit bit_idx (LSB first). After bit DATA_BITS-1, go to STOP.
  - STOP: on the 16th tick, sample rx_s.
    - rx_s=1: data_out<=shift reg; done_flag=1 for exactly one clk on the next edge; error_flag<=0.
    - rx_s=0: data_out unchanged; error_flag<=1; no done_flag.
    - Either way, return to IDLE.
- active_flag is high from the clk after the start-edge detect until the clk the STOP sample is taken (inclusive).
- error_flag is a level. It stays high until the next frame's START is entered, or until reset.
- Stop bit held low (break): IDLE waits for rx_s to return high before a new falling edge can be detected. No spurious frames.
- Back-to-back frames: a falling edge in the same cycle IDLE is re-entered is detected, since the edge detector runs in all states. There is no dead cycle requirement beyond the stop-bit half.
- Latency: done_flag asserts (8 + 16*9) ticks + 2..4 clk synchroniser/edge delay after the data_rx falling edge. At 9600 baud: 152*326 ≈ 49552 clk.
- Reset mid-frame: immediate return to IDLE, outputs at reset values, partial byte discarded.
- Tick counter width: 11 bits (max DIV 1302).

Test Plan:
- 9600 baud, send 0x55 (start, 1010_1010 LSB first, stop=1) -> data_out=8'h55, one done_flag pulse ≈49552±4 clk after start edge, error_flag=0.
- Each baud_rate 00..11, send 0xA3 using bit time 16*DIV clk -> data_out=8'hA3 and one done_flag per rate; active_flag width ≈ 9.5 bit times.
- Glitch: data_rx low for 3 ticks (3*326 clk at 9600) then high -> returns to IDLE, no done_flag, no error_flag, data_out unchanged.
- Framing error: send 0x3C with stop bit 0 -> error_flag=1, done_flag never pulses, data_out keeps previous value. Next valid frame 0x81 -> error_flag clears on START, data_out=8'h81.
- Reset mid-frame: assert rst_n=0 after bit 4 of 0xFF -> all outputs 0 immediately. Release and send 0x12 -> data_out=8'h12, single done_flag.
- Back-to-back: 0x01 then 0xFE with no idle gap at 19200, and baud_rate toggled mid-frame -> both bytes received correctly, two done_flag pulses.
